// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline controller and the pipeline stages.
// master = pipe_ctrl (drives STALL/FLUSH/redirect), slave = stage side.
`ifndef INST_ADDR_BUS
`define INST_ADDR_BUS 31:0
`endif

interface pipe_ctrl_if #(
    parameter int CNT_W = 6
);
    logic                 STALLREQ_ID;
    logic                 STALLREQ_EX;
    logic                 STALLREQ_MEM;
    logic                 MULDIV_START;
    logic [CNT_W-1:0]     MULDIV_CYCLES;
    logic                 EXCEPT_VALID;
    logic [3:0]           EXCEPT_TYPE;
    logic [`INST_ADDR_BUS] CP0_EPC;
    logic [5:0]           STALL;
    logic                 FLUSH;
    logic [`INST_ADDR_BUS] NEW_PC;
    logic                 MULDIV_BUSY;
    logic                 MULDIV_DONE;
    logic                 WDT_TRIP;

    modport master (
        input  STALLREQ_ID, STALLREQ_EX, STALLREQ_MEM,
        input  MULDIV_START, MULDIV_CYCLES,
        input  EXCEPT_VALID, EXCEPT_TYPE, CP0_EPC,
        output STALL, FLUSH, NEW_PC,
        output MULDIV_BUSY, MULDIV_DONE, WDT_TRIP
    );

    modport slave (
        output STALLREQ_ID, STALLREQ_EX, STALLREQ_MEM,
        output MULDIV_START, MULDIV_CYCLES,
        output EXCEPT_VALID, EXCEPT_TYPE, CP0_EPC,
        input  STALL, FLUSH, NEW_PC,
        input  MULDIV_BUSY, MULDIV_DONE, WDT_TRIP
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall priority, exception flush/redirect with one-cycle
// lockout, mul/div busy sequencer. Optional stall watchdog via STALL_WATCHDOG_EN.
`ifndef INST_ADDR_BUS
`define INST_ADDR_BUS 31:0
`endif

module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter int          CNT_W      = 6,
    parameter int          WDT_LIMIT  = 1023
) (
    input  logic        CLK,
    input  logic        RST,
    pipe_ctrl_if.master bus
);
    typedef enum logic {RUN, LOCK} flush_state_e;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    flush_state_e         flush_state_q, flush_state_d;
    md_state_e            md_state_q, md_state_d;
    logic [CNT_W-1:0]     md_cnt_q, md_cnt_d;
    logic                 flush;
    logic [`INST_ADDR_BUS] new_pc;
    logic [2:0]           stall_lvl;
    logic [5:0]           stall;

    // Flush FSM: an accepted exception blocks the next one for exactly one cycle.
    always_comb begin
        flush         = 1'b0;
        new_pc        = '0;
        flush_state_d = RUN;
        if (!RST && flush_state_q == RUN && bus.EXCEPT_VALID) begin
            flush         = 1'b1;
            new_pc        = (bus.EXCEPT_TYPE == 4'hE) ? bus.CP0_EPC : EXC_VECTOR;
            flush_state_d = LOCK;
        end
    end

    always_comb begin
        md_state_d = md_state_q;
        md_cnt_d   = md_cnt_q;
        case (md_state_q)
            IDLE: begin
                if (bus.MULDIV_START) begin
                    md_cnt_d   = (bus.MULDIV_CYCLES == '0) ? CNT_ONE : bus.MULDIV_CYCLES;
                    md_state_d = BUSY;
                end
            end
            BUSY: begin
                if (md_cnt_q <= CNT_ONE) begin
                    md_state_d = DONE;
                end else begin
                    md_cnt_d = md_cnt_q - CNT_ONE;
                end
            end
            DONE:    md_state_d = IDLE;
            default: md_state_d = IDLE;
        endcase
        if (flush) begin
            md_state_d = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            flush_state_q <= RUN;
            md_state_q    <= IDLE;
            md_cnt_q      <= '0;
        end else begin
            flush_state_q <= flush_state_d;
            md_state_q    <= md_state_d;
            md_cnt_q      <= md_cnt_d;
        end
    end

    // Stall depth: number of stages (from PC upward) that are held.
    always_comb begin
        stall_lvl = 3'd0;
        if (RST || flush) begin
            stall_lvl = 3'd0;
        end else if (bus.STALLREQ_MEM) begin
            stall_lvl = 3'd5;
        end else if (bus.STALLREQ_EX || md_state_q == BUSY || bus.MULDIV_START) begin
            stall_lvl = 3'd4;
        end else if (bus.STALLREQ_ID) begin
            stall_lvl = 3'd3;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_stall
            assign stall[gi] = (stall_lvl > 3'(gi));
        end
    endgenerate

    assign bus.STALL       = stall;
    assign bus.FLUSH       = flush;
    assign bus.NEW_PC      = new_pc;
    assign bus.MULDIV_BUSY = (md_state_q == BUSY);
    assign bus.MULDIV_DONE = (md_state_q == DONE);

`ifdef STALL_WATCHDOG_EN
    localparam logic [9:0] WDT_LIMIT_W = WDT_LIMIT[9:0];

    logic [9:0] wdt_cnt_q, wdt_cnt_d;
    logic       wdt_trip_q, wdt_trip_d;

    always_comb begin
        wdt_cnt_d  = wdt_cnt_q;
        wdt_trip_d = wdt_trip_q | (wdt_cnt_q >= WDT_LIMIT_W);
        if (stall == 6'b0 || flush) begin
            wdt_cnt_d = '0;
        end else if (wdt_cnt_q != 10'h3FF) begin
            wdt_cnt_d = wdt_cnt_q + 10'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wdt_cnt_q  <= '0;
            wdt_trip_q <= 1'b0;
        end else begin
            wdt_cnt_q  <= wdt_cnt_d;
            wdt_trip_q <= wdt_trip_d;
        end
    end

    assign bus.WDT_TRIP = wdt_trip_q;
`else
    assign bus.WDT_TRIP = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: reset, stall priority, mul/div sequencing,
// exception flush/lockout, flush abort of mul/div, and the stall watchdog.
`timescale 1ns/1ps

module tb_pipe_ctrl;
    logic CLK = 1'b0;
    logic RST;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 CLK = ~CLK;

    pipe_ctrl_if #(.CNT_W(6)) bus ();

    pipe_ctrl #(
        .EXC_VECTOR(32'hBFC0_0380),
        .CNT_W     (6),
        .WDT_LIMIT (8)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %h", tag, got);
        end
    endtask

    // Advance to just after the next active edge.
    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        bus.STALLREQ_ID   = 1'b0;
        bus.STALLREQ_EX   = 1'b0;
        bus.STALLREQ_MEM  = 1'b0;
        bus.MULDIV_START  = 1'b0;
        bus.MULDIV_CYCLES = 6'd0;
        bus.EXCEPT_VALID  = 1'b0;
        bus.EXCEPT_TYPE   = 4'h0;
        bus.CP0_EPC       = 32'h0;
    endtask

    initial begin
        clear_inputs();
        RST              = 1'b1;
        bus.STALLREQ_MEM = 1'b1;
        bus.EXCEPT_VALID = 1'b1;
        #1;
        check_eq("rst0_stall", 32'(bus.STALL), 32'h0);
        check_eq("rst0_flush", 32'(bus.FLUSH), 32'h0);
        check_eq("rst0_newpc", bus.NEW_PC, 32'h0);
        next_cycle();
        check_eq("rst1_stall", 32'(bus.STALL), 32'h0);
        check_eq("rst1_flush", 32'(bus.FLUSH), 32'h0);
        check_eq("rst1_newpc", bus.NEW_PC, 32'h0);
        check_eq("rst1_busy",  32'(bus.MULDIV_BUSY), 32'h0);
        check_eq("rst1_wdt",   32'(bus.WDT_TRIP), 32'h0);
        next_cycle();
        RST = 1'b0;
        clear_inputs();

        // Stall priority
        bus.STALLREQ_ID = 1'b1;
        bus.STALLREQ_EX = 1'b1;
        #1 check_eq("stall_id_ex", 32'(bus.STALL), 32'h0F);
        next_cycle();
        bus.STALLREQ_MEM = 1'b1;
        #1 check_eq("stall_mem", 32'(bus.STALL), 32'h1F);
        next_cycle();
        clear_inputs();
        #1 check_eq("stall_none", 32'(bus.STALL), 32'h00);
        next_cycle();
        bus.STALLREQ_ID = 1'b1;
        #1 check_eq("stall_id", 32'(bus.STALL), 32'h07);
        next_cycle();
        clear_inputs();
        next_cycle();

        // Mul/div, 4 cycles, with an ignored second start
        bus.MULDIV_START  = 1'b1;
        bus.MULDIV_CYCLES = 6'd4;
        #1 check_eq("md4_start_stall", 32'(bus.STALL), 32'h0F);
        check_eq("md4_start_busy", 32'(bus.MULDIV_BUSY), 32'h0);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            bus.MULDIV_START  = (i == 1);
            bus.MULDIV_CYCLES = 6'd2;
            #1;
            check_eq($sformatf("md4_busy%0d_stall", i), 32'(bus.STALL), 32'h0F);
            check_eq($sformatf("md4_busy%0d_busy", i), 32'(bus.MULDIV_BUSY), 32'h1);
            check_eq($sformatf("md4_busy%0d_done", i), 32'(bus.MULDIV_DONE), 32'h0);
        end
        next_cycle();
        clear_inputs();
        #1 check_eq("md4_done", 32'(bus.MULDIV_DONE), 32'h1);
        check_eq("md4_done_stall", 32'(bus.STALL), 32'h00);
        check_eq("md4_done_busy", 32'(bus.MULDIV_BUSY), 32'h0);
        next_cycle();
        check_eq("md4_idle_done", 32'(bus.MULDIV_DONE), 32'h0);

        // Zero-cycle request behaves as one cycle
        bus.MULDIV_START = 1'b1;
        next_cycle();
        clear_inputs();
        #1 check_eq("md0_busy", 32'(bus.MULDIV_BUSY), 32'h1);
        next_cycle();
        check_eq("md0_done", 32'(bus.MULDIV_DONE), 32'h1);
        next_cycle();

        // Exception flush overriding MEM stall, lockout, then ERET
        bus.EXCEPT_VALID = 1'b1;
        bus.EXCEPT_TYPE  = 4'h4;
        bus.STALLREQ_MEM = 1'b1;
        #1 check_eq("exc_flush", 32'(bus.FLUSH), 32'h1);
        check_eq("exc_stall", 32'(bus.STALL), 32'h00);
        check_eq("exc_newpc", bus.NEW_PC, 32'hBFC00380);
        next_cycle();
        #1 check_eq("lock_flush", 32'(bus.FLUSH), 32'h0);
        check_eq("lock_newpc", bus.NEW_PC, 32'h0);
        check_eq("lock_stall", 32'(bus.STALL), 32'h1F);
        next_cycle();
        bus.STALLREQ_MEM = 1'b0;
        bus.EXCEPT_TYPE  = 4'hE;
        bus.CP0_EPC      = 32'h8000_0040;
        #1 check_eq("eret_flush", 32'(bus.FLUSH), 32'h1);
        check_eq("eret_newpc", bus.NEW_PC, 32'h80000040);
        next_cycle();
        clear_inputs();
        next_cycle();

        // Flush aborts a running mul/div
        bus.MULDIV_START  = 1'b1;
        bus.MULDIV_CYCLES = 6'd10;
        next_cycle();
        bus.MULDIV_START = 1'b0;
        next_cycle();
        next_cycle();
        bus.EXCEPT_VALID = 1'b1;
        bus.EXCEPT_TYPE  = 4'h2;
        #1 check_eq("abort_flush", 32'(bus.FLUSH), 32'h1);
        check_eq("abort_stall", 32'(bus.STALL), 32'h00);
        check_eq("abort_busy_pre", 32'(bus.MULDIV_BUSY), 32'h1);
        next_cycle();
        clear_inputs();
        #1 check_eq("abort_busy_post", 32'(bus.MULDIV_BUSY), 32'h0);
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            check_eq($sformatf("abort_nodone%0d", i), 32'(bus.MULDIV_DONE), 32'h0);
        end

        // Stall watchdog
        bus.STALLREQ_ID = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1 check_eq($sformatf("wdt_hold%0d", i), 32'(bus.WDT_TRIP), 32'h0);
            next_cycle();
        end
        bus.STALLREQ_ID = 1'b0;
        next_cycle();
`ifdef STALL_WATCHDOG_EN
        check_eq("wdt_trip", 32'(bus.WDT_TRIP), 32'h1);
        next_cycle();
        next_cycle();
        check_eq("wdt_sticky", 32'(bus.WDT_TRIP), 32'h1);
`else
        check_eq("wdt_off", 32'(bus.WDT_TRIP), 32'h0);
        next_cycle();
        next_cycle();
        check_eq("wdt_off_late", 32'(bus.WDT_TRIP), 32'h0);
`endif
        RST = 1'b1;
        next_cycle();
        RST = 1'b0;
        check_eq("wdt_rst", 32'(bus.WDT_TRIP), 32'h0);
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
